// File: rtl/hit_pattern_gen_pkg.sv
// Shared definitions for the hit pattern generator: phase encoding and default geometry.
// Defaults line up with the TDC counter width, the 32-tap delay line and the 3-FF hit filter.
package hit_pattern_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_STOP  = 3'd3,
    ST_GAP   = 3'd4
  } hpg_state_t;

  localparam int COUNT_W_DEF   = 4;
  localparam int FINE_W_DEF    = 5;
  localparam int BURST_W_DEF   = 8;
  localparam int NFF           = 3;
  localparam int PULSE_LEN_DEF = NFF;
  localparam int IDLE_GAP_DEF  = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hit_pattern_gen_if.sv
// Command channel of the hit pattern generator: valid/ready handshake plus interval fields.
interface hit_pattern_gen_if #(
  parameter int COUNT_W = 4,
  parameter int FINE_W  = 5,
  parameter int BURST_W = 8
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [COUNT_W-1:0] cmd_coarse;
  logic [FINE_W-1:0]  cmd_fine;
  logic [BURST_W-1:0] cmd_repeat;

  modport master (
    output cmd_valid, cmd_coarse, cmd_fine, cmd_repeat,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_coarse, cmd_fine, cmd_repeat,
    output cmd_ready
  );
endinterface

// File: rtl/hit_phase_timer.sv
// Loadable down-counter that times every hit phase; zero marks the last cycle of a phase.
module hit_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - W'(1);
    end
  end

  assign zero = (cnt_reg == '0);
endmodule

// File: rtl/hit_pattern_gen.sv
// Start/stop hit pair generator: turns a coarse+fine interval command into pulse pairs on one
// hit line and publishes the count/bin the TDC should report for each pair.
module hit_pattern_gen
  import hit_pattern_gen_pkg::*;
#(
  parameter int COUNT_W   = COUNT_W_DEF,
  parameter int FINE_W    = FINE_W_DEF,
  parameter int BURST_W   = BURST_W_DEF,
  parameter int PULSE_LEN = PULSE_LEN_DEF,
  parameter int IDLE_GAP  = IDLE_GAP_DEF
) (
  input  logic               clk,
  input  logic               rst,
  hit_pattern_gen_if.slave   cmd,
  input  logic               abort,
  output logic               hit,
  output logic [FINE_W-1:0]  fine_sel,
  output logic               busy,
  output logic               exp_valid,
  output logic [COUNT_W-1:0] exp_count,
  output logic [FINE_W-1:0]  exp_bin,
  output logic               done
);
  localparam int TW = max_int(COUNT_W, max_int($clog2(PULSE_LEN + 1), $clog2(IDLE_GAP + 1)));

  hpg_state_t         state_reg, state_next;
  logic [COUNT_W-1:0] coarse_reg;
  logic [FINE_W-1:0]  fine_reg;
  logic [BURST_W-1:0] rep_reg;
  logic               hit_reg, exp_valid_reg, done_reg;
  logic [COUNT_W-1:0] exp_count_reg;
  logic [FINE_W-1:0]  exp_bin_reg;
  logic               accept, timer_load, timer_zero;
  logic [TW-1:0]      timer_val;
  logic               hit_next, strobe_next, done_next;

  assign cmd.cmd_ready = (state_reg == ST_IDLE);
  assign accept        = cmd.cmd_valid && (state_reg == ST_IDLE);

  hit_phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // The first START after accept is one cycle longer with hit held low, so hit rises one
  // cycle after the accept edge; a START entered from GAP raises hit immediately.
  always_comb begin
    state_next = state_reg;
    timer_load = 1'b0;
    timer_val  = '0;
    done_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_START;
          timer_load = 1'b1;
          timer_val  = TW'(PULSE_LEN);
        end
      end
      ST_START: begin
        if (rep_reg == '0) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end else if (timer_zero) begin
          state_next = ST_WAIT;
          timer_load = 1'b1;
          timer_val  = TW'(coarse_reg);
        end
      end
      ST_WAIT: begin
        if (timer_zero) begin
          state_next = ST_STOP;
          timer_load = 1'b1;
          timer_val  = TW'(PULSE_LEN - 1);
        end
      end
      ST_STOP: begin
        if (timer_zero) begin
          state_next = ST_GAP;
          timer_load = 1'b1;
          timer_val  = TW'(IDLE_GAP - 1);
        end
      end
      ST_GAP: begin
        if (timer_zero) begin
          if (rep_reg == BURST_W'(1)) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = ST_START;
            timer_load = 1'b1;
            timer_val  = TW'(PULSE_LEN - 1);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (abort && (state_reg != ST_IDLE)) begin
      state_next = ST_IDLE;
      done_next  = 1'b0;
      timer_load = 1'b0;
    end
  end

  assign hit_next    = (state_next == ST_STOP) ||
                       ((state_next == ST_START) && (state_reg != ST_IDLE));
  assign strobe_next = (state_reg == ST_WAIT) && (state_next == ST_STOP);

  always_ff @(posedge clk) begin
    if (rst) begin
      coarse_reg    <= '0;
      fine_reg      <= '0;
      rep_reg       <= '0;
      hit_reg       <= 1'b0;
      exp_valid_reg <= 1'b0;
      exp_count_reg <= '0;
      exp_bin_reg   <= '0;
      done_reg      <= 1'b0;
    end else begin
      hit_reg       <= hit_next;
      exp_valid_reg <= strobe_next;
      done_reg      <= done_next;
      if (accept) begin
        coarse_reg <= cmd.cmd_coarse;
        fine_reg   <= cmd.cmd_fine;
        rep_reg    <= cmd.cmd_repeat;
      end else if ((state_reg == ST_GAP) && (state_next != ST_GAP)) begin
        rep_reg <= rep_reg - BURST_W'(1);
      end
      if (strobe_next) begin
        exp_count_reg <= coarse_reg;
        exp_bin_reg   <= fine_reg;
      end
    end
  end

  assign hit       = hit_reg;
  assign fine_sel  = fine_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign exp_valid = exp_valid_reg;
  assign exp_count = exp_count_reg;
  assign exp_bin   = exp_bin_reg;
  assign done      = done_reg;
endmodule

// File: tb/tb_hit_pattern_gen.sv
// Directed bench for hit_pattern_gen: cycle numbers count from the accept edge (cycle 0 is
// the period right after it) and every expected value below is worked out by hand.
module tb_hit_pattern_gen;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       abort = 1'b0;
  logic       hit, busy, exp_valid, done;
  logic [4:0] fine_sel, exp_bin;
  logic [3:0] exp_count;

  int checks = 0;
  int failures = 0;
  int txn = 0;

  hit_pattern_gen_if #(.COUNT_W(4), .FINE_W(5), .BURST_W(8)) cmd_if ();

  hit_pattern_gen dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cmd_if),
    .abort     (abort),
    .hit       (hit),
    .fine_sel  (fine_sel),
    .busy      (busy),
    .exp_valid (exp_valid),
    .exp_count (exp_count),
    .exp_bin   (exp_bin),
    .done      (done)
  );

  always #5 clk = ~clk;

  // capture results of the last run_cmd
  int   rise_q[$];
  int   fall_q[$];
  int   n_strobe, strobe_cyc, first_cnt, first_bin;
  int   n_done, done_cyc, ready_before_done;
  logic busy_tr [0:127];
  logic ready_tr[0:127];

  task automatic check_eq(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int q_at(input int q[$], input int idx);
    return (idx < q.size()) ? q[idx] : -1;
  endfunction

  // abort_at / rst_at: cycle at which the event has taken effect (0 = never)
  task automatic run_cmd(input int coarse, input int fine, input int rep, input bit hold,
                         input int abort_at, input int rst_at, input int ncyc);
    logic prev_hit;
    rise_q.delete();
    fall_q.delete();
    n_strobe = 0; strobe_cyc = -1; first_cnt = -1; first_bin = -1;
    n_done = 0; done_cyc = -1; ready_before_done = 0;
    @(negedge clk);
    check_eq($sformatf("t%0d_ready_pre", txn), cmd_if.cmd_ready, 1);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_coarse = 4'(coarse);
    cmd_if.cmd_fine   = 5'(fine);
    cmd_if.cmd_repeat = 8'(rep);
    @(posedge clk);
    prev_hit = 1'b0;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      if (hit && !prev_hit) rise_q.push_back(n);
      if (!hit && prev_hit) fall_q.push_back(n);
      prev_hit = hit;
      if (exp_valid) begin
        if (n_strobe == 0) begin
          strobe_cyc = n; first_cnt = int'(exp_count); first_bin = int'(exp_bin);
        end
        n_strobe++;
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = n;
      end
      if (cmd_if.cmd_ready && (done_cyc < 0)) ready_before_done++;
      busy_tr[n]  = busy;
      ready_tr[n] = cmd_if.cmd_ready;
      if (!hold || (done_cyc >= 0)) cmd_if.cmd_valid = 1'b0;
      abort = (n + 1 == abort_at);
      rst   = (n + 1 == rst_at);
    end
    cmd_if.cmd_valid = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
    $display("txn %0d: coarse=%0d fine=%0d repeat=%0d rises=%0d strobes=%0d done_cyc=%0d",
             txn, coarse, fine, rep, rise_q.size(), n_strobe, done_cyc);
    txn++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_coarse = 4'd7;
    cmd_if.cmd_fine   = 5'd9;
    cmd_if.cmd_repeat = 8'd2;
    // 1. reset held two cycles while a command is offered
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_hit", hit, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_exp_valid", exp_valid, 0);
    check_eq("rst_exp_count", exp_count, 0);
    check_eq("rst_exp_bin", exp_bin, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_fine_sel", fine_sel, 0);
    check_eq("rst_ready", cmd_if.cmd_ready, 1);
    rst = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);

    // 2. single pair coarse=5 fine=17
    run_cmd(5, 17, 1, 1'b0, 0, 0, 30);
    check_eq("t2_rise0", q_at(rise_q, 0), 1);
    check_eq("t2_fall0", q_at(fall_q, 0), 4);
    check_eq("t2_rise1", q_at(rise_q, 1), 10);
    check_eq("t2_fall1", q_at(fall_q, 1), 13);
    check_eq("t2_nrise", rise_q.size(), 2);
    check_eq("t2_strobe_cyc", strobe_cyc, 10);
    check_eq("t2_exp_count", first_cnt, 5);
    check_eq("t2_exp_bin", first_bin, 17);
    check_eq("t2_nstrobe", n_strobe, 1);
    check_eq("t2_done_cyc", done_cyc, 21);
    check_eq("t2_ndone", n_done, 1);
    check_eq("t2_ready_at_done", ready_tr[21], 1);
    check_eq("t2_busy_before_done", busy_tr[20], 1);
    check_eq("t2_fine_sel", fine_sel, 17);
    check_eq("t2_exp_count_hold", exp_count, 5);

    // 3. coarse boundaries
    run_cmd(0, 4, 1, 1'b0, 0, 0, 24);
    check_eq("t3a_stop_minus_start", q_at(rise_q, 1) - q_at(rise_q, 0), 4);
    check_eq("t3a_low_cycles", q_at(rise_q, 1) - q_at(fall_q, 0), 1);
    check_eq("t3a_exp_count", first_cnt, 0);
    check_eq("t3a_done_cyc", done_cyc, 16);
    run_cmd(15, 31, 1, 1'b0, 0, 0, 40);
    check_eq("t3b_low_cycles", q_at(rise_q, 1) - q_at(fall_q, 0), 16);
    check_eq("t3b_stop_rise", q_at(rise_q, 1), 20);
    check_eq("t3b_exp_count", first_cnt, 15);
    check_eq("t3b_exp_bin", first_bin, 31);
    check_eq("t3b_done_cyc", done_cyc, 31);

    // 4. burst of 3 with cmd_valid held
    run_cmd(2, 11, 3, 1'b1, 0, 0, 60);
    check_eq("t4_nrise", rise_q.size(), 6);
    check_eq("t4_stop_rise0", q_at(rise_q, 1), 7);
    check_eq("t4_gap01", q_at(rise_q, 2) - q_at(fall_q, 1), 8);
    check_eq("t4_gap12", q_at(rise_q, 4) - q_at(fall_q, 3), 8);
    check_eq("t4_stop_rise2", q_at(rise_q, 5), 41);
    check_eq("t4_nstrobe", n_strobe, 3);
    check_eq("t4_ndone", n_done, 1);
    check_eq("t4_done_cyc", done_cyc, 52);
    check_eq("t4_ready_early", ready_before_done, 0);
    check_eq("t4_idle_after", ready_tr[55], 1);

    // 5a. repeat=0
    run_cmd(3, 21, 0, 1'b0, 0, 0, 12);
    check_eq("t5a_nrise", rise_q.size(), 0);
    check_eq("t5a_done_cyc", done_cyc, 1);
    check_eq("t5a_busy0", busy_tr[0], 1);
    check_eq("t5a_busy1", busy_tr[1], 0);
    check_eq("t5a_fine_sel", fine_sel, 21);
    // 5b. abort in WAIT
    run_cmd(10, 3, 1, 1'b0, 7, 0, 30);
    check_eq("t5b_nrise", rise_q.size(), 1);
    check_eq("t5b_busy6", busy_tr[6], 1);
    check_eq("t5b_busy7", busy_tr[7], 0);
    check_eq("t5b_ready7", ready_tr[7], 1);
    check_eq("t5b_ndone", n_done, 0);
    check_eq("t5b_nstrobe", n_strobe, 0);

    // 6. reset during STOP, then a normal command
    run_cmd(1, 6, 2, 1'b0, 0, 7, 24);
    check_eq("t6_stop_rise", q_at(rise_q, 1), 6);
    check_eq("t6_fall_at_rst", q_at(fall_q, 1), 7);
    check_eq("t6_nrise", rise_q.size(), 2);
    check_eq("t6_busy7", busy_tr[7], 0);
    check_eq("t6_ndone", n_done, 0);
    check_eq("t6_exp_count_rst", exp_count, 0);
    check_eq("t6_fine_sel_rst", fine_sel, 0);
    run_cmd(3, 9, 1, 1'b0, 0, 0, 24);
    check_eq("t6b_rise0", q_at(rise_q, 0), 1);
    check_eq("t6b_stop_rise", q_at(rise_q, 1), 8);
    check_eq("t6b_exp_count", first_cnt, 3);
    check_eq("t6b_exp_bin", first_bin, 9);
    check_eq("t6b_done_cyc", done_cyc, 19);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
